// File: rtl/duty_cycle_scheduler.sv
// duty_cycle_scheduler: walks the enabled ring-oscillator channels one at a time
// and drives an external duty-cycle measurement core for each one. For each
// channel it clears the core, waits for the input to settle, opens a fixed
// measurement window, waits for the core result, then offers that result on a
// valid/ready handshake.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   start, continuous       scan request (IDLE only); auto re-scan after last channel
//   ch_mask [N_CH]          channel enable mask, sampled at scan start
//   ring_in [N_CH]          ring-oscillator inputs
//   meas_ring               registered ring_in[cur_ch] toward the core
//   meas_enable, meas_clear core enable; one-cycle core clear
//   meas_value [17]         core result
//   result_value/_ch        captured result and its channel index
//   result_valid/_ready     result handshake
//   busy, done              scan active; one-cycle end-of-scan pulse
module duty_cycle_scheduler #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned WINDOW  = 1000,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned CAP_DLY = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                continuous,
  input  logic [N_CH-1:0]                     ch_mask,
  input  logic [N_CH-1:0]                     ring_in,
  output logic                                meas_ring,
  output logic                                meas_enable,
  output logic                                meas_clear,
  input  logic [16:0]                         meas_value,
  output logic [16:0]                         result_value,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] result_ch,
  output logic                                result_valid,
  input  logic                                result_ready,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CNT_MAX = (WINDOW >= SETTLE) ?
                                    ((WINDOW >= CAP_DLY) ? WINDOW : CAP_DLY) :
                                    ((SETTLE >= CAP_DLY) ? SETTLE : CAP_DLY);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_MEASURE, S_CAPTURE, S_HOLD, S_NEXT
  } state_t;

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [N_CH-1:0]   r_mask, w_mask_next;
  logic [CH_W-1:0]   r_cur_ch, w_cur_ch_next;
  logic [CH_W-1:0]   w_low_ch;
  logic [CH_W-1:0]   w_nxt_ch;
  logic              w_has_nxt;
  logic              w_done_c;
  logic              w_xfer;

  logic              r_meas_ring, r_meas_enable, r_meas_clear;
  logic              r_result_valid, r_busy, r_done;
  logic [16:0]       r_result_value;
  logic [CH_W-1:0]   r_result_ch;

  assign w_xfer = r_result_valid & result_ready;

  // Lowest enabled channel of the live mask (used when a scan begins).
  always_comb begin
    w_low_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) w_low_ch = CH_W'(i);
    end
  end

  // Next enabled channel above cur_ch in the latched mask.
  always_comb begin
    w_nxt_ch  = '0;
    w_has_nxt = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(r_cur_ch))) begin
        w_nxt_ch  = CH_W'(i);
        w_has_nxt = 1'b1;
      end
    end
  end

  // Next-state, counter and channel selection.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_mask_next   = r_mask;
    w_cur_ch_next = r_cur_ch;
    w_done_c      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (|ch_mask)) begin
          w_state_next  = S_CLEAR;
          w_mask_next   = ch_mask;
          w_cur_ch_next = w_low_ch;
          w_cnt_next    = '0;
        end
      end
      S_CLEAR: begin
        w_state_next = S_SETTLE;
        w_cnt_next   = '0;
      end
      S_SETTLE: begin
        if (r_cnt == CNT_W'(SETTLE - 1)) begin
          w_state_next = S_MEASURE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_MEASURE: begin
        if (r_cnt == CNT_W'(WINDOW - 1)) begin
          w_state_next = S_CAPTURE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        if (r_cnt == CNT_W'(CAP_DLY - 1)) begin
          w_state_next = S_HOLD;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (w_xfer) w_state_next = S_NEXT;
      end
      S_NEXT: begin
        if (w_has_nxt) begin
          w_state_next  = S_CLEAR;
          w_cur_ch_next = w_nxt_ch;
        end else begin
          w_done_c = 1'b1;
          // Continuous mode re-samples the live mask for the following scan.
          if (continuous && (|ch_mask)) begin
            w_state_next  = S_CLEAR;
            w_mask_next   = ch_mask;
            w_cur_ch_next = w_low_ch;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Datapath and registered outputs; outputs trail the state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt          <= '0;
      r_mask         <= '0;
      r_cur_ch       <= '0;
      r_meas_ring    <= 1'b0;
      r_meas_enable  <= 1'b0;
      r_meas_clear   <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_value <= '0;
      r_result_ch    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_next;
      r_mask         <= w_mask_next;
      r_cur_ch       <= w_cur_ch_next;
      r_meas_ring    <= ring_in[r_cur_ch];
      r_meas_enable  <= (r_state == S_MEASURE);
      r_meas_clear   <= (r_state == S_CLEAR);
      r_busy         <= (r_state != S_IDLE);
      r_done         <= w_done_c;
      // Valid drops on the cycle after the accepting edge.
      r_result_valid <= (r_state == S_HOLD) && !w_xfer;
      // Capture once, on the edge that raises valid, so value and ch stay put.
      if ((r_state == S_HOLD) && !r_result_valid) begin
        r_result_value <= meas_value;
        r_result_ch    <= r_cur_ch;
      end
    end
  end

  assign meas_ring    = r_meas_ring;
  assign meas_enable  = r_meas_enable;
  assign meas_clear   = r_meas_clear;
  assign result_value = r_result_value;
  assign result_ch    = r_result_ch;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_duty_cycle_scheduler.sv
// Directed bench for duty_cycle_scheduler (N_CH=4, WINDOW=16, SETTLE=4, CAP_DLY=2).
// Edge numbers count rising edges after the edge that samples start (edge 0).
module tb_duty_cycle_scheduler;

  localparam int unsigned N_CH    = 4;
  localparam int unsigned WINDOW  = 16;
  localparam int unsigned SETTLE  = 4;
  localparam int unsigned CAP_DLY = 2;

  logic        clk = 1'b0;
  logic        reset, start, continuous;
  logic [3:0]  ch_mask, ring_in;
  logic        meas_ring, meas_enable, meas_clear;
  logic [16:0] meas_value, result_value;
  logic [1:0]  result_ch;
  logic        result_valid, result_ready, busy, done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  duty_cycle_scheduler #(
    .N_CH(N_CH), .WINDOW(WINDOW), .SETTLE(SETTLE), .CAP_DLY(CAP_DLY)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .ring_in(ring_in), .meas_ring(meas_ring),
    .meas_enable(meas_enable), .meas_clear(meas_clear), .meas_value(meas_value),
    .result_value(result_value), .result_ch(result_ch),
    .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [3:0] mask);
    ch_mask = mask;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_meas_ring"},    meas_ring,    0);
    check({pfx, "_meas_enable"},  meas_enable,  0);
    check({pfx, "_meas_clear"},   meas_clear,   0);
    check({pfx, "_result_valid"}, result_valid, 0);
    check({pfx, "_result_value"}, result_value, 0);
    check({pfx, "_result_ch"},    result_ch,    0);
    check({pfx, "_busy"},         busy,         0);
    check({pfx, "_done"},         done,         0);
  endtask

  initial begin
    int bad, wait_e, rises, done_n, clr_n, rv_hi;
    int rv_edge[4];
    logic [1:0]  rv_ch[4];
    logic [16:0] rv_val[4];
    logic prev_rv, exp_ring;

    reset = 1'b1; start = 1'b0; continuous = 1'b0; ch_mask = '0;
    ring_in = '0; meas_value = 17'd123; result_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("init");
    reset = 1'b0;
    tick();

    // Start with an empty mask is ignored.
    bad = 0;
    ch_mask = 4'b0000; start = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (busy || meas_clear) bad++;
    end
    start = 1'b0;
    check("mask0_idle", bad, 0);

    // HOLD with ready low for 10 cycles.
    result_ready = 1'b0; meas_value = 17'd123;
    start_scan(4'b0001);
    wait_e = 0;
    for (int e = 1; e <= 40 && !result_valid; e++) begin
      tick();
      wait_e = e;
    end
    check("hold_rv_edge", wait_e, 24);
    meas_value = 17'd999;
    bad = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (!result_valid || result_value != 17'd123 || result_ch != 2'd0 || meas_clear || !busy) bad++;
    end
    check("hold_stable", bad, 0);
    result_ready = 1'b1;
    tick();
    check("hold_rv_drop", result_valid, 0);
    tick();
    check("hold_done", done, 1);
    tick();
    check("hold_busy_low", busy, 0);

    // Two-channel scan, mask change mid-scan ignored.
    meas_value = 17'd123; result_ready = 1'b1;
    start_scan(4'b0101);
    ch_mask = 4'b0010;
    rises = 0; done_n = 0; clr_n = 0; rv_hi = 0; prev_rv = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      tick();
      if (result_valid && !prev_rv) begin
        if (rises < 4) begin
          rv_edge[rises] = e; rv_ch[rises] = result_ch; rv_val[rises] = result_value;
        end
        rises++;
      end
      prev_rv = result_valid;
      if (result_valid) rv_hi++;
      if (done) done_n++;
      if (meas_clear) clr_n++;
      if (e == 1)  check("scan_clear_e1", meas_clear, 1);
      if (e == 5)  check("scan_en_e5", meas_enable, 0);
      if (e == 6)  check("scan_en_e6", meas_enable, 1);
      if (e == 21) check("scan_en_e21", meas_enable, 1);
      if (e == 22) check("scan_en_e22", meas_enable, 0);
      if (e == 52) check("scan_done_e52", done, 1);
    end
    check("scan_rises", rises, 2);
    check("scan_rv0_edge", rv_edge[0], 24);
    check("scan_rv0_ch", rv_ch[0], 0);
    check("scan_rv0_val", rv_val[0], 123);
    check("scan_rv1_edge", rv_edge[1], 50);
    check("scan_rv1_ch", rv_ch[1], 2);
    check("scan_rv_cycles", rv_hi, 2);
    check("scan_done_cnt", done_n, 1);
    check("scan_clear_cnt", clr_n, 2);
    check("scan_busy_end", busy, 0);

    // Ring follow on channel 1, then reset in MEASURE cycle 10 alongside start.
    start_scan(4'b0010);
    bad = 0;
    for (int e = 1; e <= 15; e++) begin
      ring_in = 4'($urandom);
      ring_in[1] = (e < 8) ? e[0] : 1'b1;
      exp_ring = ring_in[1];
      tick();
      if (meas_ring !== exp_ring) bad++;
    end
    check("ring_follow", bad, 0);
    check("ring_in_measure", meas_enable, 1);
    ring_in = 4'b1111;
    reset = 1'b1; start = 1'b1; ch_mask = 4'b0010;
    tick();
    check_reset_outputs("rst_meas");
    reset = 1'b0; start = 1'b0;
    tick(); tick();
    check("rst_stay_idle", busy, 0);
    check("rst_no_clear", meas_clear, 0);

    // Continuous scans on channel 3, dropped during the third scan.
    meas_value = 17'd77; continuous = 1'b1; result_ready = 1'b1;
    start_scan(4'b1000);
    rises = 0; done_n = 0; bad = 0; prev_rv = 1'b0;
    for (int e = 1; e <= 90; e++) begin
      if (e == 60) continuous = 1'b0;
      tick();
      if (result_valid && !prev_rv) begin
        if (rises < 4) rv_edge[rises] = e;
        if (result_ch != 2'd3 || result_value != 17'd77) bad++;
        rises++;
      end
      prev_rv = result_valid;
      if (done) done_n++;
    end
    check("cont_rises", rises, 3);
    check("cont_rv0_edge", rv_edge[0], 24);
    check("cont_rv1_edge", rv_edge[1], 50);
    check("cont_rv2_edge", rv_edge[2], 76);
    check("cont_ch_val", bad, 0);
    check("cont_done_cnt", done_n, 3);
    check("cont_busy_end", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
